// File: rtl/floppy_pkg.sv
// Shared types and constants for the floppy byte-stream path.
// Contents: FSM state enum, CRC-CCITT constants, stream beat payload struct,
// and crc16_byte(), a byte-wide MSB-first CRC-CCITT step built from 8 serial shifts.
package floppy_pkg;

    localparam int unsigned IDX_W  = 11;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CRC_W  = 16;

    localparam logic [CRC_W-1:0] CRC_POLY    = 16'h1021;
    localparam logic [CRC_W-1:0] CRC_INIT    = 16'hFFFF;
    // CRC state after A1 A1 A1 FE (ID address mark)
    localparam logic [CRC_W-1:0] IDAM_PRESET = 16'hB230;
    // CRC state after A1 A1 A1 FB (data address mark)
    localparam logic [CRC_W-1:0] DAM_PRESET  = 16'hE295;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        HDR  = 2'd2,
        DATA = 2'd3
    } state_e;

    // One emitted stream byte with its qualifiers
    typedef struct packed {
        logic [BYTE_W-1:0] data;
        logic              is_hdr;
        logic [IDX_W-1:0]  idx;
    } stream_beat_t;

    // Fold one byte into the CRC, MSB first
    function automatic logic [CRC_W-1:0] crc16_byte(input logic [CRC_W-1:0] crc,
                                                    input logic [BYTE_W-1:0] data);
        logic [CRC_W-1:0] c;
        c = crc;
        for (int i = BYTE_W - 1; i >= 0; i--) begin
            if (c[CRC_W-1] ^ data[i]) begin
                c = {c[CRC_W-2:0], 1'b0} ^ CRC_POLY;
            end else begin
                c = {c[CRC_W-2:0], 1'b0};
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/floppy_byte_stream_crc16.sv
// Byte-wide CRC-CCITT register, shared between the ID field and data field.
// Ports: clk, rst_n (async active-low), preset (start from preset_val this
// cycle), preset_val, en (fold data this cycle), data, crc (current value).
// preset and en together fold the first byte on top of the preset value.
module floppy_crc16
    import floppy_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              preset,
    input  logic [CRC_W-1:0]  preset_val,
    input  logic              en,
    input  logic [BYTE_W-1:0] data,
    output logic [CRC_W-1:0]  crc
);

    logic [CRC_W-1:0] base_c;

    // Starting point of this cycle's fold
    always_comb base_c = preset ? preset_val : crc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc16_byte(base_c, data);
        end else if (preset) begin
            crc <= preset_val;
        end
    end

endmodule

// File: rtl/floppy_byte_stream.sv
// Converts the virtual drive's header/data windows into a byte-serial stream.
// Header window: emits track, side, sector, size code, ID CRC, then GAP_BYTE.
// Data window: pops bytes from the sector buffer, substitutes 00 and flags
// a sticky underrun when the buffer is empty.
// Inputs : clk, rst_n, dclk_en, ready, sector_hdr, sector_data, track, sector,
//          side, size_code, buf_data, buf_valid, underrun_clr
// Outputs: buf_rd, byte_out, byte_valid, byte_is_hdr, byte_idx, underrun,
//          data_crc, data_crc_valid
// Build option: define FLOPPY_DATA_CRC_EN to compute the data-field CRC;
// otherwise data_crc/data_crc_valid are tied low.
module floppy_byte_stream
    import floppy_pkg::*;
#(
    parameter int unsigned       HDR_LEN         = 6,
    parameter logic [7:0]        GAP_BYTE        = 8'h4E,
    parameter logic [15:0]       IDAM_CRC_PRESET = IDAM_PRESET
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              dclk_en,
    input  logic              ready,
    input  logic              sector_hdr,
    input  logic              sector_data,
    input  logic [6:0]        track,
    input  logic [4:0]        sector,
    input  logic              side,
    input  logic [1:0]        size_code,
    input  logic [7:0]        buf_data,
    input  logic              buf_valid,
    output logic              buf_rd,
    output logic [7:0]        byte_out,
    output logic              byte_valid,
    output logic              byte_is_hdr,
    output logic [IDX_W-1:0]  byte_idx,
    output logic              underrun,
    input  logic              underrun_clr,
    output logic [CRC_W-1:0]  data_crc,
    output logic              data_crc_valid
);

    state_e            state;
    logic [IDX_W-1:0]  idx;
    logic [CRC_W-1:0]  crc;
    stream_beat_t      beat;

    logic              strobe_c;
    logic              go_hdr_c, in_hdr_c, go_data_c, in_data_c;
    logic              hdr_emit_c, data_emit_c;
    logic [IDX_W-1:0]  emit_idx_c;
    logic [7:0]        hdr_byte_c, data_byte_c;
    logic              crc_preset_c, crc_en_c;
    logic [CRC_W-1:0]  crc_preset_val_c;
    logic [7:0]        crc_data_c;

    // A decision slot: byte strobe while the drive is ready
    always_comb strobe_c = dclk_en & ready;

    // Window entry/continuation; header wins when both windows are high
    always_comb begin
        go_hdr_c    = strobe_c & sector_hdr & ((state == GAP) | (state == DATA));
        in_hdr_c    = strobe_c & sector_hdr & (state == HDR);
        go_data_c   = strobe_c & ~sector_hdr & sector_data & (state == HDR);
        in_data_c   = strobe_c & ~sector_hdr & sector_data & (state == DATA);
        hdr_emit_c  = go_hdr_c | in_hdr_c;
        data_emit_c = go_data_c | in_data_c;
        emit_idx_c  = (go_hdr_c | go_data_c) ? '0 : idx;
    end

    // ID field byte for the current header position
    always_comb begin
        hdr_byte_c = GAP_BYTE;
        if (32'(emit_idx_c) < HDR_LEN) begin
            case (emit_idx_c)
                IDX_W'(0): hdr_byte_c = {1'b0, track};
                IDX_W'(1): hdr_byte_c = {7'b0, side};
                IDX_W'(2): hdr_byte_c = {3'b0, sector};
                IDX_W'(3): hdr_byte_c = {6'b0, size_code};
                IDX_W'(4): hdr_byte_c = crc[15:8];
                IDX_W'(5): hdr_byte_c = crc[7:0];
                default:   hdr_byte_c = GAP_BYTE;
            endcase
        end
        data_byte_c = buf_valid ? buf_data : 8'h00;
    end

    // CRC control: ID bytes 0..3 are folded, the CRC bytes read the frozen value
    always_comb begin
        crc_preset_c     = go_hdr_c;
        crc_preset_val_c = IDAM_CRC_PRESET;
        crc_en_c         = hdr_emit_c & (emit_idx_c < IDX_W'(4));
        crc_data_c       = hdr_byte_c;
`ifdef FLOPPY_DATA_CRC_EN
        if (go_data_c) begin
            crc_preset_c     = 1'b1;
            crc_preset_val_c = DAM_PRESET;
        end
        if (data_emit_c) begin
            crc_en_c   = 1'b1;
            crc_data_c = data_byte_c;
        end
`endif
    end

    floppy_crc16 u_crc (
        .clk        (clk),
        .rst_n      (rst_n),
        .preset     (crc_preset_c),
        .preset_val (crc_preset_val_c),
        .en         (crc_en_c),
        .data       (crc_data_c),
        .crc        (crc)
    );

    // Window-tracking FSM with registered stream outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            beat       <= '0;
            byte_valid <= 1'b0;
            buf_rd     <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            byte_valid  <= 1'b0;
            buf_rd      <= 1'b0;
            beat.is_hdr <= 1'b0;
            if (underrun_clr) begin
                underrun <= 1'b0;
            end

            // Losing ready drops sync at once; realignment needs a gap
            if (!ready) begin
                state <= IDLE;
            end else if (dclk_en) begin
                case (state)
                    IDLE: if (!sector_hdr && !sector_data) state <= GAP;
                    GAP:  if (sector_hdr) state <= HDR;
                    HDR:  if (!sector_hdr) state <= sector_data ? DATA : GAP;
                    DATA: begin
                        if (sector_hdr) begin
                            state <= HDR;
                        end else if (!sector_data) begin
                            state <= GAP;
                        end
                    end
                endcase
            end

            if (hdr_emit_c | data_emit_c) begin
                byte_valid <= 1'b1;
                beat       <= '{data:   hdr_emit_c ? hdr_byte_c : data_byte_c,
                                is_hdr: hdr_emit_c,
                                idx:    emit_idx_c};
                idx        <= emit_idx_c + IDX_W'(1);
                buf_rd     <= data_emit_c & buf_valid;
                // Set after the clear so a coincident underrun wins
                if (data_emit_c & ~buf_valid) begin
                    underrun <= 1'b1;
                end
            end
        end
    end

    assign byte_out    = beat.data;
    assign byte_is_hdr = beat.is_hdr;
    assign byte_idx    = beat.idx;

`ifdef FLOPPY_DATA_CRC_EN
    logic data_exit_c;

    // Data window closes on a strobe that does not continue it
    always_comb data_exit_c = strobe_c & (state == DATA) & ~(sector_data & ~sector_hdr);

    // Data CRC result, captured when the data window closes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_crc       <= '0;
            data_crc_valid <= 1'b0;
        end else begin
            data_crc_valid <= data_exit_c;
            if (data_exit_c) begin
                data_crc <= crc;
            end
        end
    end
`else
    assign data_crc       = '0;
    assign data_crc_valid = 1'b0;
`endif

endmodule

// File: doc/floppy_byte_stream.md
Name: floppy_byte_stream

Overview:
Downstream consumer of the virtual floppy drive's timing outputs (dclk_en, sector_hdr, sector_data, track, sector, ready). Turns the header and data windows into a byte-serial stream for the FDC read path. During the header window it emits the ID field: track, side, sector, size code and CRC. During the data window it pops bytes from the sector buffer and flags underrun.

Parameters:
HDR_LEN, 6, header window length in bytes; must match the drive's header window length
GAP_BYTE, 8'h4E, byte emitted for header-window bytes beyond HDR_LEN-1
IDAM_CRC_PRESET, 16'hB230, CRC-CCITT state after A1 A1 A1 FE

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
dclk_en  in  1  one-cycle byte strobe from the drive
ready  in  1  drive ready
sector_hdr  in  1  header window active
sector_data  in  1  data window active
track  in  7  track under head
sector  in  5  sector under head
side  in  1  head/side select
size_code  in  2  ID size code: 0=128, 1=256, 2=512, 3=1024
buf_data  in  8  sector buffer head byte
buf_valid  in  1  buf_data valid
buf_rd  out  1  one-cycle pop of the sector buffer
byte_out  out  8  stream byte
byte_valid  out  1  one-cycle strobe qualifying byte_out
byte_is_hdr  out  1  byte_out belongs to the ID field
byte_idx  out  11  byte position within the current window
underrun  out  1  sticky: a data byte was needed while buf_valid=0
underrun_clr  in  1  clears underrun
data_crc  out  16  data-field CRC (optional feature)
data_crc_valid  out  1  one-cycle strobe (optional feature)

Behaviour:
- Reset values: all outputs 0; state IDLE; synced=0; crc=16'hFFFF.
- All decisions happen only in cycles with dclk_en=1. sector_hdr, sector_data and ready are sampled in that cycle.
- Latency: byte_out, byte_valid, byte_is_hdr and byte_idx are registered and appear exactly 1 clk after the dclk_en cycle. buf_rd pulses in that same output cycle.
- States:
  - IDLE: no bytes emitted. On a dclk_en cycle with both windows low (gap) -> GAP, synced=1.
  - GAP: on a dclk_en cycle with sector_hdr=1 -> HDR, idx=0. With sector_data=1 and no header seen yet -> stay GAP (partial sector; not emitted).
  - HDR: emit by idx:
    - 0: {1'b0, track}
    - 1: {7'b0, side}
    - 2: {3'b0, sector}
    - 3: {6'b0, size_code}
    - 4: crc[15:8]
    - 5: crc[7:0]
    - idx >= HDR_LEN: GAP_BYTE
  - HDR CRC and transitions:
    - crc is preset to IDAM_CRC_PRESET when HDR is entered.
    - Bytes 0..3 are folded in MSB-first, poly 0x1021, one byte per dclk_en.
    - Bytes 4 and 5 are taken from the frozen crc.
    - sector_hdr low with sector_data high -> DATA, idx=0.
    - Both low -> GAP.
  - DATA:
    - buf_valid=1: byte_out=buf_data, buf_rd=1.
    - buf_valid=0: byte_out=8'h00, buf_rd=0, underrun<=1.
    - sector_data low -> GAP.
- byte_is_hdr=1 only for bytes emitted in HDR.
- byte_idx increments per emitted byte. It wraps 2047->0 without error.
- ready=0 in any cycle (not only dclk_en): immediately -> IDLE, synced=0, nothing emitted, buf_rd=0. The next sector is aligned only after a gap is observed.
- sector_hdr and sector_data both high: header has priority, data is ignored.
- underrun_clr and a new underrun in the same cycle: the set wins.
- Asserting rst_n low mid-window aborts the sector. After reset, resync waits for a gap.

Optional Feature:
FLOPPY_DATA_CRC_EN
- Defined:
  - On entry to DATA, crc is preset to 16'hE295 (A1 A1 A1 FB).
  - Every emitted data byte, including 00 substitutes on underrun, is folded in.
  - On the dclk_en cycle where DATA exits, data_crc is driven with the result and data_crc_valid pulses 1 clk later.
  - Exit by ready=0 produces no strobe.
- Undefined: data_crc=0 and data_crc_valid=0 constantly; no data CRC logic.

Decomposition:
- Shared package floppy_pkg:
  - state enum (IDLE, GAP, HDR, DATA)
  - CRC_POLY=16'h1021
  - IDAM/DAM preset constants
  - a function crc16_byte(crc, byte) doing 8 serial steps.
- One natural sub-module: floppy_crc16 (byte-wide CRC register with preset/enable/load), reused for header and data CRC.

Test Plan:
- track=12, side=1, sector=3, size_code=2, 6-byte hdr window -> bytes 0C 01 03 02 then CRC-CCITT of A1A1A1FE 0C 01 03 02 (bench model), byte_is_hdr=1 ×6.
- Data window of 512 bytes, buf_valid=1 with incrementing pattern -> 512 buf_rd pulses, byte_out matches pattern, underrun=0.
- buf_valid dropped for bytes 100..101 -> byte_out=00 at idx 100, 101; underrun=1 until underrun_clr; set-wins check when both occur together.
- ready deasserted at header idx 2 and reasserted mid-data -> nothing emitted until the next gap, then the full next sector is emitted from idx 0.
- Reset asserted mid-data -> all outputs 0 asynchronously; the first emitted byte after reset is header idx 0 of a later sector.
- With FLOPPY_DATA_CRC_EN, 256 bytes of 0xE5 -> data_crc equals the bench model, with a single data_crc_valid pulse 1 clk after data window exit.
